// File: rtl/mem_if.sv
// Bus bundle for the 6502 main memory: CPU access signals plus the bulk-load and monitor views.
interface mem_if #(
  parameter int DEPTH      = 256,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                   we;
  logic [WIDTH-1:0]       din;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [WIDTH-1:0]       dout;
  logic                   override_mem;
  logic [DEPTH*WIDTH-1:0] mem_override_in;
  logic [DEPTH*WIDTH-1:0] mem_monitor;

  modport master (
    output we, din, addr, override_mem, mem_override_in,
    input  dout, mem_monitor
  );

  modport slave (
    input  we, din, addr, override_mem, mem_override_in,
    output dout, mem_monitor
  );
endinterface

// File: rtl/mem.sv
// Single-port byte-wide main memory with registered read, whole-array bulk load and flat monitor view.
module mem #(
  parameter int DEPTH      = 256,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 16
) (
  input logic   clk,
  input logic   reset,
  mem_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             inRange;
  logic [IDX_W-1:0] idx;

  assign inRange = (bus.addr < ADDR_WIDTH'(DEPTH));
  assign idx     = bus.addr[IDX_W-1:0];

  // Out-of-range addresses neither alias nor write; they read back as zero.
  always_comb begin
    dout_d = inRange ? mem_q[idx] : '0;
    mem_d  = mem_q;
    if (bus.override_mem) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = bus.mem_override_in[i*WIDTH +: WIDTH];
      end
    end else if (bus.we && inRange) begin
      mem_d[idx] = bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;

  for (genvar g = 0; g < DEPTH; g++) begin : gMonitor
    assign bus.mem_monitor[g*WIDTH +: WIDTH] = mem_q[g];
  end
endmodule

// File: tb/tb_mem.sv
// Scoreboard bench for mem: the driver queues expected results, a monitor pops and compares them after each edge.
module tb_mem;
  localparam int DEPTH = 256;
  localparam int WIDTH = 8;
  localparam int AW    = 16;
  localparam int FLAT  = DEPTH * WIDTH;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard queues, one entry per driven cycle
  logic            chkDoutQ [$];
  logic [7:0]      expDoutQ [$];
  logic            chkMonQ  [$];
  logic [FLAT-1:0] expMonQ  [$];
  string           nameQ    [$];

  logic [FLAT-1:0] refImage;
  logic [FLAT-1:0] rampImage;
  logic [FLAT-1:0] invImage;
  logic [FLAT-1:0] zeroImage;

  task automatic applyStimulus(input logic rst, input logic we, input logic [AW-1:0] addr,
                               input logic [7:0] din, input logic ovr, input logic [FLAT-1:0] image,
                               input logic [7:0] expDout, input logic chkMon, input string name);
    @(negedge clk);
    reset                  = rst;
    bus.we                 = we;
    bus.addr               = addr;
    bus.din                = din;
    bus.override_mem       = ovr;
    bus.mem_override_in    = image;
    if (rst)                      refImage = '0;
    else if (ovr)                 refImage = image;
    else if (we && addr < DEPTH)  refImage[addr[7:0]*WIDTH +: WIDTH] = din;
    chkDoutQ.push_back(1'b1);
    expDoutQ.push_back(expDout);
    chkMonQ.push_back(chkMon);
    expMonQ.push_back(refImage);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expDout,
                             input logic chkMon, input logic [FLAT-1:0] expMon);
    checks++;
    if (bus.dout !== expDout) begin
      failures++;
      $display("[TB] FAIL %s dout: got %h expected %h", name, bus.dout, expDout);
    end
    if (chkMon) begin
      checks++;
      if (bus.mem_monitor !== expMon) begin
        failures++;
        for (int i = 0; i < DEPTH; i++) begin
          if (bus.mem_monitor[i*WIDTH +: WIDTH] !== expMon[i*WIDTH +: WIDTH]) begin
            $display("[TB] FAIL %s mem_monitor word %0d: got %h expected %h", name, i,
                     bus.mem_monitor[i*WIDTH +: WIDTH], expMon[i*WIDTH +: WIDTH]);
            break;
          end
        end
      end
    end
  endtask

  initial begin : monitorProc
    forever begin
      @(posedge clk);
      #1;
      if (nameQ.size() > 0) begin
        string      nm;
        logic       cd;
        logic [7:0] ed;
        logic       cm;
        logic [FLAT-1:0] em;
        nm = nameQ.pop_front();
        cd = chkDoutQ.pop_front();
        ed = expDoutQ.pop_front();
        cm = chkMonQ.pop_front();
        em = expMonQ.pop_front();
        if (cd) checkOutput(nm, ed, cm, em);
      end
    end
  end

  initial begin : driverProc
    int drain;
    checks    = 0;
    failures  = 0;
    refImage  = '0;
    zeroImage = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rampImage[i*WIDTH +: WIDTH] = 8'(i);
      invImage[i*WIDTH +: WIDTH]  = ~8'(i);
    end
    reset = 1'b1; bus.we = 1'b0; bus.addr = '0; bus.din = '0;
    bus.override_mem = 1'b0; bus.mem_override_in = '0;

    applyStimulus(1, 0, 16'h0000, 8'h00, 0, zeroImage, 8'h00, 1, "reset0");
    applyStimulus(1, 0, 16'h0000, 8'h00, 0, zeroImage, 8'h00, 1, "reset1");
    applyStimulus(0, 1, 16'h0003, 8'hA5, 0, zeroImage, 8'h00, 1, "wrA5");
    applyStimulus(1, 0, 16'h0003, 8'h00, 0, zeroImage, 8'h00, 1, "resetClr");
    applyStimulus(0, 0, 16'h0003, 8'h00, 0, zeroImage, 8'h00, 1, "rd3AfterRst");
    applyStimulus(0, 1, 16'h0010, 8'h3C, 0, zeroImage, 8'h00, 1, "wr3COld");
    applyStimulus(0, 0, 16'h0010, 8'h00, 0, zeroImage, 8'h3C, 1, "rd10");
    applyStimulus(0, 0, 16'h0042, 8'h00, 1, rampImage, 8'h00, 1, "ovrRamp");
    applyStimulus(0, 0, 16'h0042, 8'h00, 0, zeroImage, 8'h42, 1, "rd42");
    applyStimulus(0, 1, 16'h0005, 8'hFF, 1, rampImage, 8'h05, 1, "ovrBeatsWe");
    applyStimulus(0, 0, 16'h0005, 8'h00, 0, zeroImage, 8'h05, 1, "rd5");
    applyStimulus(1, 0, 16'h0005, 8'h00, 1, rampImage, 8'h00, 1, "rstBeatsOvr");
    applyStimulus(0, 1, 16'h0000, 8'h5A, 0, zeroImage, 8'h00, 1, "wr0");
    applyStimulus(0, 1, 16'h0100, 8'h77, 0, zeroImage, 8'h00, 1, "wrOutOfRange");
    applyStimulus(0, 0, 16'h0100, 8'h00, 0, zeroImage, 8'h00, 1, "rdOutOfRange");
    applyStimulus(0, 0, 16'hFFFF, 8'h00, 0, zeroImage, 8'h00, 0, "rdFFFF");
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, zeroImage, 8'h5A, 1, "rd0NoAlias");
    applyStimulus(0, 1, 16'h0000, 8'h01, 0, zeroImage, 8'h5A, 0, "b2bWr0");
    applyStimulus(0, 1, 16'h0001, 8'h02, 0, zeroImage, 8'h00, 0, "b2bWr1");
    applyStimulus(0, 1, 16'h0002, 8'h03, 0, zeroImage, 8'h00, 1, "b2bWr2");
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, zeroImage, 8'h01, 0, "b2bRd0");
    applyStimulus(0, 0, 16'h0001, 8'h00, 0, zeroImage, 8'h02, 0, "b2bRd1");
    applyStimulus(0, 0, 16'h0002, 8'h00, 0, zeroImage, 8'h03, 1, "b2bRd2");
    applyStimulus(0, 0, 16'h0001, 8'hxx, 0, zeroImage, 8'h02, 1, "dinXNoWe");
    applyStimulus(0, 0, 16'h0001, 8'h00, 0, zeroImage, 8'h02, 1, "rd1AfterX");
    applyStimulus(0, 1, 16'h0000, 8'hEE, 1, invImage, 8'h01, 1, "ovrHold0");
    applyStimulus(0, 1, 16'h0000, 8'hEE, 1, invImage, 8'hFF, 1, "ovrHold1");
    applyStimulus(0, 0, 16'h0000, 8'h00, 0, zeroImage, 8'hFF, 1, "rd0AfterOvr");
    applyStimulus(0, 0, 16'h00FF, 8'h00, 0, zeroImage, 8'h00, 1, "rdTopWord");

    @(negedge clk);
    bus.we = 1'b0;
    bus.override_mem = 1'b0;
    drain = 0;
    while (nameQ.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    if (nameQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", nameQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem.md
Name: mem

Overview:
- Single-port, byte-wide main memory for the 6502 system.
- The CPU writes and reads one word per clock through `addr`/`din`/`dout`.
- For simulation benches, the block also accepts a whole-array bulk load (`override_mem` / `mem_override_in`) and exposes its full contents as a flat vector (`mem_monitor`).
- Sits between the CPU data/address bus and the test infrastructure; it runs on the inverted CPU phase clock.

Parameters:
- DEPTH, 256, number of stored words; valid addresses are 0..DEPTH-1.
- WIDTH, 8, word width in bits (matches the 6502 register width).
- ADDR_WIDTH, 16, address bus width (matches the 6502 address bus).

Ports:
- clk  in  1  memory clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable; 1 = write `din` to `addr` this edge.
- din  in  WIDTH  write data.
- addr  in  ADDR_WIDTH  word address for read and write.
- dout  out  WIDTH  registered read data.
- override_mem  in  1  1 = bulk-load the entire array from `mem_override_in` this edge.
- mem_override_in  in  DEPTH*WIDTH  flat load image; word i = bits [i*WIDTH +: WIDTH].
- mem_monitor  out  DEPTH*WIDTH  flat view of current contents; word i = bits [i*WIDTH +: WIDTH].

Behaviour:
- Storage: array of DEPTH words of WIDTH bits. There is no other state besides the `dout` register.

Update priority on each rising clk edge (highest first):
1. reset=1: every word <= 0; dout <= 0. `we` and `override_mem` are ignored.
2. override_mem=1: every word i <= mem_override_in[i*WIDTH +: WIDTH] in the same edge. `we` is ignored. dout <= pre-edge contents of word `addr` (0 if out of range).
3. we=1 and addr < DEPTH: word[addr] <= din.
4. Otherwise: the array holds.

Read path:
- When not in reset, dout <= pre-edge word[addr] on every edge, regardless of `we`.
- Read latency is 1 clock.
- Simultaneous read/write to the same address returns the OLD data; the new data is visible on the following edge.

Out-of-range address (addr >= DEPTH):
- Writes are dropped; no aliasing or wrap-around.
- dout <= 0.

mem_monitor:
- Purely combinational from the array.
- Reflects every array update immediately after the edge that causes it.
- No reset dependency beyond the array itself.

Other rules:
- `din` is sampled only when we=1. X/Z on `din` with we=0 must not corrupt the array.
- Reset asserted mid-operation (e.g. in the same cycle as a write or override) wins; the array is all zero after that edge.
- Override held high for several cycles reloads the image every cycle; writes are blocked for the whole duration.
- No handshakes. The block is always ready; one access per clock.

Test Plan:
- Reset: write 8'hA5 to addr 3, then assert reset one cycle → next cycle mem_monitor all zero, dout=0, read of addr 3 returns 8'h00.
- Write/read: we=1, addr=16'h0010, din=8'h3C; next cycle we=0, addr=16'h0010 → dout=8'h3C one clock later. A same-cycle read during the write returns the old value 8'h00.
- Bulk override: mem_override_in with word i = i[7:0], override_mem=1 for one cycle → mem_monitor equals the image; read addr 16'h0042 → dout=8'h42.
- Priority: override_mem=1 and we=1 to addr 5 with din=8'hFF in the same cycle, image word 5 = 8'h05 → word 5 = 8'h05. Then reset=1 with override_mem=1 → array all zero.
- Out of range: we=1, addr=DEPTH (16'h0100), din=8'h77 → mem_monitor unchanged (word 0 unaffected); read of addr 16'h0100 → dout=8'h00.
- Back-to-back: writes of 8'h01, 8'h02, 8'h03 to addresses 0, 1, 2 on consecutive cycles, then reads of addresses 0, 1, 2 on consecutive cycles → dout sequence 01, 02, 03, each one clock after its address.
